multi_cycle_ctrl: RTL and testbench

//  Moore FSM that sequences a shared multi-cycle MIPS datapath: one memory, one ALU, one register file.

---
 rtl/multi_cycle_ctrl_if.sv | 35 +++
 rtl/multi_cycle_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_multi_cycle_ctrl.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/multi_cycle_ctrl_if.sv
// Handshake/control bundle between the multi-cycle controller (master) and the shared datapath (slave).
interface multi_cycle_ctrl_if;
  logic [5:0] op_code;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic       ir_write;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;
  logic [3:0] state;
  logic       illegal_op;
  logic       bus_err;

  modport master (
    input  op_code, zero, mem_ready,
    output pc_write, ir_write, i_or_d, mem_read, mem_write, mem_to_reg,
           reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
           state, illegal_op, bus_err
  );

  modport slave (
    output op_code, zero, mem_ready,
    input  pc_write, ir_write, i_or_d, mem_read, mem_write, mem_to_reg,
           reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
           state, illegal_op, bus_err
  );
endinterface

// File: rtl/multi_cycle_ctrl.sv
// Moore controller sequencing a shared multi-cycle MIPS datapath (lw/sw/beq/R-type/j/addi).
// Define PERF_CNT_EN to add the instr_cnt completed-fetch counter port.
//
// state  | meaning
// IDLE   | post-reset, fetch next
// FETCH  | read instruction at PC, PC+4
// DECODE | register read, branch target
// MEMADR | lw/sw effective address
// MEMRD  | data read
// MEMWB  | load write-back
// MEMWR  | data write
// EXEC   | R-type ALU op
// RWB    | R-type write-back
// BRANCH | beq compare, conditional PC load
// JUMP   | PC <- jump target
// ADDIEX | addi ALU op
// ADDIWB | addi write-back
module multi_cycle_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  multi_cycle_ctrl_if.master  bus
`ifdef PERF_CNT_EN
  ,
  output logic [31:0]         instr_cnt
`endif
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    MEMADR = 4'd3,
    MEMRD  = 4'd4,
    MEMWB  = 4'd5,
    MEMWR  = 4'd6,
    EXEC   = 4'd7,
    RWB    = 4'd8,
    BRANCH = 4'd9,
    JUMP   = 4'd10,
    ADDIEX = 4'd11,
    ADDIWB = 4'd12
  } stateT;

  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpAddi  = 6'b001000;

  localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(MEM_TIMEOUT - 1);

  if (MEM_TIMEOUT < 2 || (2 ** CNT_W) < MEM_TIMEOUT) begin : gBadParams
    $error("multi_cycle_ctrl: MEM_TIMEOUT must be >= 2 and fit in CNT_W bits");
  end

  stateT            stateQ, stateD;
  logic [CNT_W-1:0] waitCntQ, waitCntD;
  logic             memState;
  logic             memWaiting;
  logic             memTimeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ   <= IDLE;
      waitCntQ <= '0;
    end else begin
      stateQ   <= stateD;
      waitCntQ <= waitCntD;
    end
  end

  // The counter only runs while a memory state is stalled; a timeout clears it so a retried fetch gets a full window.
  always_comb begin
    memState   = (stateQ == FETCH) || (stateQ == MEMRD) || (stateQ == MEMWR);
    memWaiting = memState && !bus.mem_ready;
    memTimeout = memWaiting && (waitCntQ == TimeoutCnt);
    waitCntD   = '0;
    if (memWaiting && !memTimeout) begin
      waitCntD = waitCntQ + CNT_W'(1);
    end
  end

  always_comb begin
    stateD         = stateQ;
    bus.pc_write   = 1'b0;
    bus.ir_write   = 1'b0;
    bus.i_or_d     = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.reg_write  = 1'b0;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = 2'b00;
    bus.alu_op     = 2'b00;
    bus.pc_source  = 2'b00;
    bus.illegal_op = 1'b0;
    bus.bus_err    = 1'b0;

    case (stateQ)
      IDLE: stateD = FETCH;

      FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = 2'b01;
        bus.ir_write  = bus.mem_ready;
        bus.pc_write  = bus.mem_ready;
        if (bus.mem_ready) begin
          stateD = DECODE;
        end else if (memTimeout) begin
          bus.bus_err = 1'b1;
          stateD      = FETCH;
        end
      end

      DECODE: begin
        bus.alu_src_b = 2'b11;
        case (bus.op_code)
          OpLw, OpSw: stateD = MEMADR;
          OpRtype:    stateD = EXEC;
          OpBeq:      stateD = BRANCH;
          OpJ:        stateD = JUMP;
          OpAddi:     stateD = ADDIEX;
          default: begin
            bus.illegal_op = 1'b1;
            stateD         = FETCH;
          end
        endcase
      end

      MEMADR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        if (bus.op_code == OpSw) begin
          stateD = MEMWR;
        end else if (bus.op_code == OpLw) begin
          stateD = MEMRD;
        end else begin
          stateD = FETCH;
        end
      end

      MEMRD: begin
        bus.mem_read = 1'b1;
        bus.i_or_d   = 1'b1;
        if (bus.mem_ready) begin
          stateD = MEMWB;
        end else if (memTimeout) begin
          bus.bus_err = 1'b1;
          stateD      = FETCH;
        end
      end

      MEMWB: begin
        bus.mem_to_reg = 1'b1;
        bus.reg_write  = 1'b1;
        stateD         = FETCH;
      end

      MEMWR: begin
        bus.mem_write = 1'b1;
        bus.i_or_d    = 1'b1;
        if (bus.mem_ready) begin
          stateD = FETCH;
        end else if (memTimeout) begin
          bus.bus_err = 1'b1;
          stateD      = FETCH;
        end
      end

      EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = 2'b10;
        stateD        = RWB;
      end

      RWB: begin
        bus.reg_dst   = 1'b1;
        bus.reg_write = 1'b1;
        stateD        = FETCH;
      end

      BRANCH: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = 2'b01;
        bus.pc_source = 2'b01;
        bus.pc_write  = bus.zero;
        stateD        = FETCH;
      end

      JUMP: begin
        bus.pc_source = 2'b10;
        bus.pc_write  = 1'b1;
        stateD        = FETCH;
      end

      ADDIEX: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        bus.alu_op    = 2'b11;
        stateD        = ADDIWB;
      end

      ADDIWB: begin
        bus.reg_write = 1'b1;
        stateD        = FETCH;
      end

      default: stateD = FETCH;
    endcase
  end

  assign bus.state = stateQ;

`ifdef PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_cnt <= '0;
    end else if (bus.ir_write) begin
      instr_cnt <= instr_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Self-checking bench for multi_cycle_ctrl: vector table through a scoreboard queue plus
// hand-written timeout / reset / perf-counter sequences.
module tb_multi_cycle_ctrl;

  localparam logic [3:0] S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_MEMADR = 4'd3,
                         S_MEMRD = 4'd4, S_MEMWB = 4'd5, S_MEMWR = 4'd6, S_EXEC = 4'd7,
                         S_RWB = 4'd8, S_BRANCH = 4'd9, S_JUMP = 4'd10, S_ADDIEX = 4'd11,
                         S_ADDIWB = 4'd12;

  localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_R = 6'b000000,
                         OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000,
                         OP_ILL = 6'b111111;

  // Packed control word: {pc_write, ir_write, i_or_d, mem_read, mem_write, mem_to_reg,
  // reg_dst, reg_write, alu_src_a, alu_src_b[1:0], alu_op[1:0], pc_source[1:0], illegal_op, bus_err}
  localparam logic [16:0] PCW = 17'h1 << 16, IRW = 17'h1 << 15, IOD = 17'h1 << 14,
                          MRD = 17'h1 << 13, MWR = 17'h1 << 12, M2R = 17'h1 << 11,
                          RDST = 17'h1 << 10, RW = 17'h1 << 9, SRCA = 17'h1 << 8,
                          SRCB4 = 17'h1 << 6, SRCBIMM = 17'h2 << 6, SRCBSH = 17'h3 << 6,
                          OPSUB = 17'h1 << 4, OPFN = 17'h2 << 4, OPADDI = 17'h3 << 4,
                          PCSAO = 17'h1 << 2, PCSJ = 17'h2 << 2, ILL = 17'h2, BERR = 17'h1;

  localparam logic [16:0] C_F1   = PCW | IRW | MRD | SRCB4;
  localparam logic [16:0] C_F0   = MRD | SRCB4;
  localparam logic [16:0] C_DEC  = SRCBSH;
  localparam logic [16:0] C_MADR = SRCA | SRCBIMM;
  localparam logic [16:0] C_MRD  = MRD | IOD;
  localparam logic [16:0] C_MWB  = M2R | RW;
  localparam logic [16:0] C_MWR  = MWR | IOD;
  localparam logic [16:0] C_EXEC = SRCA | OPFN;
  localparam logic [16:0] C_RWB  = RDST | RW;
  localparam logic [16:0] C_BR   = SRCA | OPSUB | PCSAO;
  localparam logic [16:0] C_JMP  = PCSJ | PCW;
  localparam logic [16:0] C_AEX  = SRCA | SRCBIMM | OPADDI;
  localparam logic [16:0] C_AWB  = RW;

  typedef struct {
    logic [5:0]  op;
    logic        zero;
    logic        rdy;
    logic [3:0]  st;
    logic [16:0] ctl;
  } vecT;

  typedef struct {
    logic [3:0]  st;
    logic [16:0] ctl;
    string       name;
  } expT;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  vecT  vecs[$];
  expT  expQ[$];

  multi_cycle_ctrl_if bus();

`ifdef PERF_CNT_EN
  logic [31:0] instrCnt;
  multi_cycle_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus), .instr_cnt(instrCnt));
`else
  multi_cycle_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, summary not printed");
    $fatal(1, "watchdog");
  end

  function automatic logic [16:0] actCtl();
    return {bus.pc_write, bus.ir_write, bus.i_or_d, bus.mem_read, bus.mem_write,
            bus.mem_to_reg, bus.reg_dst, bus.reg_write, bus.alu_src_a, bus.alu_src_b,
            bus.alu_op, bus.pc_source, bus.illegal_op, bus.bus_err};
  endfunction

  task automatic addVec(input logic [5:0] op, input logic z, input logic r,
                        input logic [3:0] st, input logic [16:0] ctl);
    vecT v;
    v.op = op; v.zero = z; v.rdy = r; v.st = st; v.ctl = ctl;
    vecs.push_back(v);
  endtask

  task automatic compareHead();
    expT e;
    if (expQ.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard: queue empty, actual state %0d", bus.state);
      return;
    end
    e = expQ.pop_front();
    checks++;
    if (bus.state !== e.st) begin
      failures++;
      $display("FAIL %s state: actual %0d expected %0d", e.name, bus.state, e.st);
    end
    checks++;
    if (actCtl() !== e.ctl) begin
      failures++;
      $display("FAIL %s ctl: actual %05h expected %05h", e.name, actCtl(), e.ctl);
    end
  endtask

  // Called just after a falling edge: drive inputs, check the settled outputs, advance one cycle.
  task automatic step(input logic [5:0] op, input logic z, input logic r,
                      input logic [3:0] st, input logic [16:0] ctl, input string nm);
    expT e;
    bus.op_code   = op;
    bus.zero      = z;
    bus.mem_ready = r;
    e.st = st; e.ctl = ctl; e.name = nm;
    expQ.push_back(e);
    #2;
    compareHead();
    @(negedge clk);
  endtask

  task automatic doReset(input string nm);
    expT e;
    bus.mem_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    e.st = S_IDLE; e.ctl = '0; e.name = nm;
    expQ.push_back(e);
    #1;
    compareHead();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    rst_n         = 1'b0;
    bus.op_code   = '0;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b0;

    // lw, beq taken / not taken, illegal, R-type, j, addi, fetch stall, sw
    addVec(OP_LW, 0, 1, S_IDLE, '0);
    addVec(OP_LW, 0, 1, S_FETCH, C_F1);
    addVec(OP_LW, 0, 1, S_DECODE, C_DEC);
    addVec(OP_LW, 0, 1, S_MEMADR, C_MADR);
    addVec(OP_LW, 0, 1, S_MEMRD, C_MRD);
    addVec(OP_LW, 0, 1, S_MEMWB, C_MWB);
    addVec(OP_BEQ, 1, 1, S_FETCH, C_F1);
    addVec(OP_BEQ, 1, 1, S_DECODE, C_DEC);
    addVec(OP_BEQ, 1, 1, S_BRANCH, C_BR | PCW);
    addVec(OP_BEQ, 0, 1, S_FETCH, C_F1);
    addVec(OP_BEQ, 0, 1, S_DECODE, C_DEC);
    addVec(OP_BEQ, 0, 1, S_BRANCH, C_BR);
    addVec(OP_ILL, 0, 1, S_FETCH, C_F1);
    addVec(OP_ILL, 0, 1, S_DECODE, C_DEC | ILL);
    addVec(OP_R, 0, 1, S_FETCH, C_F1);
    addVec(OP_R, 0, 1, S_DECODE, C_DEC);
    addVec(OP_R, 0, 1, S_EXEC, C_EXEC);
    addVec(OP_R, 0, 1, S_RWB, C_RWB);
    addVec(OP_J, 0, 1, S_FETCH, C_F1);
    addVec(OP_J, 0, 1, S_DECODE, C_DEC);
    addVec(OP_J, 0, 1, S_JUMP, C_JMP);
    addVec(OP_ADDI, 0, 1, S_FETCH, C_F1);
    addVec(OP_ADDI, 0, 1, S_DECODE, C_DEC);
    addVec(OP_ADDI, 0, 1, S_ADDIEX, C_AEX);
    addVec(OP_ADDI, 0, 1, S_ADDIWB, C_AWB);
    addVec(OP_SW, 0, 0, S_FETCH, C_F0);
    addVec(OP_SW, 0, 0, S_FETCH, C_F0);
    addVec(OP_SW, 0, 1, S_FETCH, C_F1);
    addVec(OP_SW, 0, 1, S_DECODE, C_DEC);
    addVec(OP_SW, 0, 1, S_MEMADR, C_MADR);
    addVec(OP_SW, 0, 0, S_MEMWR, C_MWR);
    addVec(OP_SW, 0, 1, S_MEMWR, C_MWR);
    addVec(OP_SW, 0, 1, S_FETCH, C_F1);

    #3;
    begin
      expT e;
      e.st = S_IDLE; e.ctl = '0; e.name = "reset";
      expQ.push_back(e);
      compareHead();
    end
`ifdef PERF_CNT_EN
    checks++;
    if (instrCnt !== 32'd0) begin
      failures++;
      $display("FAIL perf_reset: actual %0d expected 0", instrCnt);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i])
      step(vecs[i].op, vecs[i].zero, vecs[i].rdy, vecs[i].st, vecs[i].ctl,
           $sformatf("vec%0d", i));

    // sw stalls in MEMWR: timeout on the 16th waiting cycle, then fetch timeout and retry
    doReset("reset_seq1");
    step(OP_SW, 0, 1, S_IDLE, '0, "sw_to_idle");
    step(OP_SW, 0, 1, S_FETCH, C_F1, "sw_fetch");
    step(OP_SW, 0, 1, S_DECODE, C_DEC, "sw_decode");
    step(OP_SW, 0, 1, S_MEMADR, C_MADR, "sw_memadr");
    for (int k = 0; k < 15; k++)
      step(OP_SW, 0, 0, S_MEMWR, C_MWR, $sformatf("sw_wait%0d", k));
    step(OP_SW, 0, 0, S_MEMWR, C_MWR | BERR, "sw_timeout");
    for (int k = 0; k < 15; k++)
      step(OP_SW, 0, 0, S_FETCH, C_F0, $sformatf("fetch_wait%0d", k));
    step(OP_SW, 0, 0, S_FETCH, C_F0 | BERR, "fetch_timeout");
    step(OP_LW, 0, 1, S_FETCH, C_F1, "fetch_retry");

    // lw: mem_ready arriving on the timeout cycle is a success
    step(OP_LW, 0, 1, S_DECODE, C_DEC, "lw_decode");
    step(OP_LW, 0, 1, S_MEMADR, C_MADR, "lw_memadr");
    for (int k = 0; k < 15; k++)
      step(OP_LW, 0, 0, S_MEMRD, C_MRD, $sformatf("lw_wait%0d", k));
    step(OP_LW, 0, 1, S_MEMRD, C_MRD, "lw_late_ready");
    step(OP_LW, 0, 1, S_MEMWB, C_MWB, "lw_memwb");

    // reset falling in the middle of MEMWR kills mem_write immediately
    step(OP_SW, 0, 1, S_FETCH, C_F1, "rst_fetch");
    step(OP_SW, 0, 1, S_DECODE, C_DEC, "rst_decode");
    step(OP_SW, 0, 1, S_MEMADR, C_MADR, "rst_memadr");
    step(OP_SW, 0, 0, S_MEMWR, C_MWR, "rst_memwr0");
    step(OP_SW, 0, 0, S_MEMWR, C_MWR, "rst_memwr1");
    doReset("reset_mid_memwr");

    // R-type, j, addi: three completed fetches by the third DECODE
    step(OP_R, 0, 1, S_IDLE, '0, "p_idle");
    step(OP_R, 0, 1, S_FETCH, C_F1, "p_fetch1");
    step(OP_R, 0, 1, S_DECODE, C_DEC, "p_decode1");
    step(OP_R, 0, 1, S_EXEC, C_EXEC, "p_exec");
    step(OP_R, 0, 1, S_RWB, C_RWB, "p_rwb");
    step(OP_J, 0, 1, S_FETCH, C_F1, "p_fetch2");
    step(OP_J, 0, 1, S_DECODE, C_DEC, "p_decode2");
    step(OP_J, 0, 1, S_JUMP, C_JMP, "p_jump");
    step(OP_ADDI, 0, 1, S_FETCH, C_F1, "p_fetch3");
    bus.op_code = OP_ADDI;
    #2;
    checks++;
    if (bus.state !== S_DECODE) begin
      failures++;
      $display("FAIL p_decode3 state: actual %0d expected %0d", bus.state, S_DECODE);
    end
`ifdef PERF_CNT_EN
    checks++;
    if (instrCnt !== 32'd3) begin
      failures++;
      $display("FAIL perf_cnt: actual %0d expected 3", instrCnt);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
